// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and constants for the chunked add/subtract unit.
// Optional saturation is enabled by defining ADDSUB_SATURATE_EN (see addsub_chunked.sv).
package addsub_pkg;

    // FSM state encoding; values match the localparam constants in the top.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    // Operation select encoding.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_chunked_if.sv
// addsub_chunked_if: request/result bundle of the chunked add/subtract unit.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge where
// valid && ready. The request side (op/a/b) is sampled only on that edge. The
// result side (s and flags) is held stable while out_valid is high until the
// transfer edge; the producer never withdraws valid before the transfer.
interface addsub_chunked_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ov;
    logic             neg;
    logic             zero;

    // Requester / result consumer side.
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, s, cout, ov, neg, zero
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, s, cout, ov, neg, zero
    );
endinterface

// File: rtl/somador_chunk.sv
// somador_chunk: combinational CHUNK-bit ripple adder built from full-adder
// cells (one generate iteration per bit), with carry in and carry out.
module somador_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    // c[i] is the carry into bit i; c[CHUNK] leaves the chunk.
    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        // Full-adder cell: sum and majority carry.
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cout = c[CHUNK];

endmodule

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle add/subtract, CHUNK bits per clock through one
// shared ripple adder with the carry held between cycles.
// Define ADDSUB_SATURATE_EN to clamp the result on signed overflow.
module addsub_chunked
    import addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_chunked_if.slave bus,
    output addsub_state_t dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int MSB    = WIDTH - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    logic [1:0]       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;      // b for add, ~b for subtract
    logic             carry;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] s_reg;
    logic             cout_r;
    logic             ov_r;
    logic             neg_r;
    logic             zero_r;

    logic [31:0]      sh;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             chunk_cout;
    logic             last_chunk;
    logic [WIDTH-1:0] raw_s;
    logic             raw_ov;
    logic [WIDTH-1:0] final_s;

    // Select the current chunk of both operands.
    always_comb begin
        sh      = 32'(idx) * 32'(CHUNK);
        a_chunk = CHUNK'(a_reg >> sh);
        b_chunk = CHUNK'(b_reg >> sh);
    end

    somador_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (sum_chunk),
        .cout (chunk_cout)
    );

    // Merge the new chunk into the result and derive overflow/saturation.
    always_comb begin
        last_chunk = (idx == IDXW'(NCHUNK - 1));
        raw_s      = (s_reg & ~(CHUNK_MASK << sh)) | (WIDTH'(sum_chunk) << sh);
        // Overflow uses the effective B operand, so one rule covers add and sub.
        raw_ov     = (a_reg[MSB] == b_reg[MSB]) && (raw_s[MSB] != a_reg[MSB]);
`ifdef ADDSUB_SATURATE_EN
        final_s    = raw_s;
        if (raw_ov) begin
            final_s = a_reg[MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        final_s    = raw_s;
`endif
    end

    // FSM, operand capture, chunk sequencing and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            s_reg  <= '0;
            cout_r <= 1'b0;
            ov_r   <= 1'b0;
            neg_r  <= 1'b0;
            zero_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.a;
                        b_reg <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
                        // Subtract is a + ~b + 1: the +1 rides in as carry.
                        carry <= bus.op;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    carry <= chunk_cout;
                    idx   <= idx + 1'b1;
                    if (last_chunk) begin
                        s_reg  <= final_s;
                        cout_r <= chunk_cout;
                        ov_r   <= raw_ov;
                        neg_r  <= final_s[MSB];
                        zero_r <= (final_s == '0);
                        state  <= ST_DONE;
                    end else begin
                        s_reg <= raw_s;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake and result outputs.
    always_comb begin
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.s         = s_reg;
        bus.cout      = cout_r;
        bus.ov        = ov_r;
        bus.neg       = neg_r;
        bus.zero      = zero_r;
        dbg_state     = addsub_state_t'(state);
    end

endmodule

// File: tb/tb_addsub_chunked.sv
// tb_addsub_chunked: directed bench for addsub_chunked (WIDTH=8, CHUNK=4).
// Expected values follow ADDSUB_SATURATE_EN when it is defined.
module tb_addsub_chunked;
    import addsub_pkg::*;

    logic          clk;
    logic          rst_n;
    addsub_state_t dbg_state;
    int            total;
    int            bad;
    int            lat;

    addsub_chunked_if #(.WIDTH(8)) bus ();

    addsub_chunked #(
        .WIDTH (8),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic [7:0] es, input logic ec,
                             input logic eo, input logic en, input logic ez);
        check({tag, ".s"},    32'(bus.s),    32'(es));
        check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
        check({tag, ".ov"},   32'(bus.ov),   32'(eo));
        check({tag, ".neg"},  32'(bus.neg),  32'(en));
        check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    endtask

    // Issue one operation, scramble inputs after accept, wait (bounded) for out_valid.
    task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y,
                          output int l);
        @(negedge clk);
        bus.op       = o;
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op       = ~o;
        bus.a        = ~x;
        bus.b        = ~y;
        l = 0;
        while (!bus.out_valid && l < 20) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    // Complete the output handshake and check the unit is ready next cycle.
    task automatic finish_op(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".in_ready_after"},  32'(bus.in_ready),  32'd1);
        check({tag, ".out_valid_after"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] e_s;
        logic       e_neg;
        total = 0;
        bad   = 0;
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset values
        #3;
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.state",     32'(dbg_state),     32'(IDLE));
        check_res("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Subtract 5 - 3
        run_op(OP_SUB, 8'h05, 8'h03, lat);
        check("sub53.latency", 32'(lat), 32'd2);
        check_res("sub53", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("sub53");

        // Subtract 3 - 5 (borrow)
        run_op(OP_SUB, 8'h03, 8'h05, lat);
        check("sub35.latency", 32'(lat), 32'd2);
        check_res("sub35", 8'hFE, 1'b0, 1'b0, 1'b1, 1'b0);
        finish_op("sub35");

        // Subtract equal operands
        run_op(OP_SUB, 8'h42, 8'h42, lat);
        check_res("sub42", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        finish_op("sub42");

        // Subtract 0x80 - 1 (signed overflow)
`ifdef ADDSUB_SATURATE_EN
        e_s = 8'h80; e_neg = 1'b1;
`else
        e_s = 8'h7F; e_neg = 1'b0;
`endif
        run_op(OP_SUB, 8'h80, 8'h01, lat);
        check_res("sub80", e_s, 1'b1, 1'b1, e_neg, 1'b0);
        finish_op("sub80");

        // Add 0x7F + 1 (signed overflow)
`ifdef ADDSUB_SATURATE_EN
        e_s = 8'h7F; e_neg = 1'b0;
`else
        e_s = 8'h80; e_neg = 1'b1;
`endif
        run_op(OP_ADD, 8'h7F, 8'h01, lat);
        check_res("add7f", e_s, 1'b0, 1'b1, e_neg, 1'b0);
        finish_op("add7f");

        // Plain add with carry out of the top chunk
        run_op(OP_ADD, 8'hC8, 8'h5A, lat);
        check_res("addc8", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);
        finish_op("addc8");

        // Backpressure: result held, new requests ignored
        run_op(OP_SUB, 8'h05, 8'h03, lat);
        check("bp.latency", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.op       = OP_ADD;
            bus.a        = 8'($urandom_range(0, 255));
            bus.b        = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
            check("bp.in_ready",  32'(bus.in_ready),  32'd0);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check_res("bp", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        bus.in_valid = 1'b0;
        finish_op("bp");
        repeat (3) @(posedge clk);
        #1;
        check("bp.no_capture_valid", 32'(bus.out_valid), 32'd0);
        check("bp.no_capture_state", 32'(dbg_state),     32'(IDLE));

        // Reset one cycle into RUN drops the operation
        @(negedge clk);
        bus.op       = OP_ADD;
        bus.a        = 8'h11;
        bus.b        = 8'h22;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("rr.state_run", 32'(dbg_state), 32'(RUN));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rr.out_valid", 32'(bus.out_valid), 32'd0);
        check("rr.state",     32'(dbg_state),     32'(IDLE));
        check_res("rr", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("rr.no_result", 32'(bus.out_valid), 32'd0);
        end

        // Normal operation after reset
        run_op(OP_ADD, 8'h10, 8'h20, lat);
        check("add10.latency", 32'(lat), 32'd2);
        check_res("add10", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        finish_op("add10");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
